// File: rtl/hilo_seq_ctrl_if.sv
// rtl/hilo_seq_ctrl_if.sv - Hi/Lo sequencer bus between the issue stage and the multiply/divide controller.
interface hilo_seq_ctrl_if;
    logic        valid_in;
    logic [5:0]  funct;
    logic        divisor_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        ready;
    logic        load;
    logic        mul_step;
    logic        div_step;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        stall;
    logic        div_by_zero;

    modport master (
        output valid_in, funct, divisor_zero, res_hi, res_lo,
        input  ready, load, mul_step, div_step, hilo_we, hi_out, lo_out, stall, div_by_zero
    );

    modport slave (
        input  valid_in, funct, divisor_zero, res_hi, res_lo,
        output ready, load, mul_step, div_step, hilo_we, hi_out, lo_out, stall, div_by_zero
    );
endinterface

// File: rtl/hilo_seq_ctrl.sv
// rtl/hilo_seq_ctrl.sv - MULTU/DIVU sequencer owning the Hi/Lo registers and the MFHI/MFLO interlock.
module hilo_seq_ctrl #(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    hilo_seq_ctrl_if.slave  bus
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_div_q, op_div_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            ready_q, ready_d;
    logic            load_q, load_d;
    logic            mul_step_q, mul_step_d;
    logic            div_step_q, div_step_d;
    logic            hilo_we_q, hilo_we_d;
    logic            dbz_q, dbz_d;
    logic            is_multu, is_divu, accept;

    assign is_multu = (bus.funct == F_MULTU);
    assign is_divu  = (bus.funct == F_DIVU);
    assign accept   = bus.valid_in && (state_q == IDLE) && (is_multu || is_divu);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_div_d = is_divu;
                    // A zero divisor never starts the unit; only the error pulse is raised.
                    if (is_divu && bus.divisor_zero) dbz_d = 1'b1;
                    else                             state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == CNT_LAST) state_d = WRITE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            WRITE: begin
                hi_d    = bus.res_hi;
                lo_d    = bus.res_lo;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they are registered yet aligned with the state.
        ready_d    = (state_d == IDLE);
        load_d     = (state_d == LOAD);
        mul_step_d = (state_d == RUN) && !op_div_d;
        div_step_d = (state_d == RUN) &&  op_div_d;
        hilo_we_d  = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            ready_q    <= 1'b1;
            load_q     <= 1'b0;
            mul_step_q <= 1'b0;
            div_step_q <= 1'b0;
            hilo_we_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            ready_q    <= ready_d;
            load_q     <= load_d;
            mul_step_q <= mul_step_d;
            div_step_q <= div_step_d;
            hilo_we_q  <= hilo_we_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.load        = load_q;
    assign bus.mul_step    = mul_step_q;
    assign bus.div_step    = div_step_q;
    assign bus.hilo_we     = hilo_we_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.stall       = bus.valid_in && (state_q != IDLE)
                             && ((bus.funct == F_MFHI) || (bus.funct == F_MFLO));
endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// tb/tb_hilo_seq_ctrl.sv - Directed self-checking bench for hilo_seq_ctrl.
module tb_hilo_seq_ctrl;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    hilo_seq_ctrl_if bus ();

    hilo_seq_ctrl #(.ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs for the accepting edge must already be driven; the first step is that edge.
    task automatic run_checked(input bit is_div, input int side_i, input logic [5:0] side_funct,
                               input logic side_stall, input logic [31:0] eh, input logic [31:0] el);
        int steps;
        step();
        sample();
        chk("load_after_accept", 32'(bus.load), 32'd1);
        chk("ready_in_load", 32'(bus.ready), 32'd0);
        steps = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == side_i) begin
                bus.valid_in = 1'b1;
                bus.funct    = side_funct;
            end
            sample();
            if (bus.mul_step || bus.div_step) steps++;
            chk("mul_step_run", 32'(bus.mul_step), 32'(!is_div));
            chk("div_step_run", 32'(bus.div_step), 32'(is_div));
            chk("load_in_run", 32'(bus.load | bus.hilo_we), 32'd0);
            if (i >= side_i) chk("stall_run", 32'(bus.stall), 32'(side_stall));
        end
        chk("step_count", 32'(steps), 32'd32);
        step();
        sample();
        chk("hilo_we_write", 32'(bus.hilo_we), 32'd1);
        chk("steps_off_write", 32'(bus.mul_step | bus.div_step | bus.load), 32'd0);
        chk("ready_in_write", 32'(bus.ready), 32'd0);
        step();
        sample();
        chk("hilo_we_done", 32'(bus.hilo_we), 32'd0);
        chk("ready_done", 32'(bus.ready), 32'd1);
        chk("stall_done", 32'(bus.stall), 32'd0);
        chk("hi_out_done", bus.hi_out, eh);
        chk("lo_out_done", bus.lo_out, el);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst              = 1'b0;
        bus.valid_in     = 1'b1;
        bus.funct        = F_MFHI;
        bus.divisor_zero = 1'b0;
        bus.res_hi       = 32'h0000_0001;
        bus.res_lo       = 32'h8000_0000;

        repeat (3) step();
        sample();
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_strobes", {27'd0, bus.load, bus.mul_step, bus.div_step, bus.hilo_we, bus.div_by_zero}, 32'd0);
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_lo", bus.lo_out, 32'd0);
        chk("rst_stall_idle", 32'(bus.stall), 32'd0);
        rst = 1'b1;
        step();
        bus.funct = F_MULTU;

        // MULTU with an MFLO interlock raised from T+5
        run_checked(1'b0, 3, F_MFLO, 1'b1, 32'h0000_0001, 32'h8000_0000);
        bus.valid_in = 1'b0;

        // DIVU by zero: error pulse only, Hi/Lo retained
        step();
        bus.valid_in     = 1'b1;
        bus.funct        = F_DIVU;
        bus.divisor_zero = 1'b1;
        step();
        bus.valid_in = 1'b0;
        sample();
        chk("dbz_pulse", 32'(bus.div_by_zero), 32'd1);
        chk("dbz_ready", 32'(bus.ready), 32'd1);
        chk("dbz_no_load", 32'(bus.load), 32'd0);
        step();
        sample();
        chk("dbz_pulse_end", 32'(bus.div_by_zero), 32'd0);
        chk("dbz_no_load2", 32'(bus.load), 32'd0);
        chk("dbz_hi_kept", bus.hi_out, 32'h0000_0001);
        chk("dbz_lo_kept", bus.lo_out, 32'h8000_0000);

        // MULTU with DIVU held throughout; the DIVU is taken only once the MULTU retires
        bus.divisor_zero = 1'b0;
        bus.res_hi       = 32'hDEAD_BEEF;
        bus.res_lo       = 32'h1234_5678;
        step();
        bus.valid_in = 1'b1;
        bus.funct    = F_MULTU;
        run_checked(1'b0, 0, F_DIVU, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        bus.res_hi = 32'h0000_0003;
        bus.res_lo = 32'h0000_0007;
        run_checked(1'b1, 0, F_DIVU, 1'b0, 32'h0000_0003, 32'h0000_0007);
        bus.valid_in = 1'b0;

        // Reset during RUN at counter 10 aborts without a Hi/Lo write
        step();
        bus.valid_in = 1'b1;
        bus.funct    = F_MULTU;
        bus.res_hi   = 32'hFFFF_FFFF;
        bus.res_lo   = 32'hFFFF_FFFF;
        step();
        bus.valid_in = 1'b0;
        repeat (11) step();
        sample();
        chk("pre_abort_mul_step", 32'(bus.mul_step), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_mul_step", 32'(bus.mul_step), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_hi", bus.hi_out, 32'd0);
        chk("abort_lo", bus.lo_out, 32'd0);
        step();
        sample();
        chk("abort_no_we", 32'(bus.hilo_we), 32'd0);
        rst          = 1'b1;
        bus.res_hi   = 32'h0000_0005;
        bus.res_lo   = 32'h0000_0009;
        bus.valid_in = 1'b1;
        bus.funct    = F_MULTU;

        // Fresh MULTU after reset with an ADD presented mid-run
        run_checked(1'b0, 4, F_ADD, 1'b0, 32'h0000_0005, 32'h0000_0009);
        bus.valid_in = 1'b0;
        step();
        sample();
        chk("final_ready", 32'(bus.ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_seq_ctrl.md
HILO_SEQ_CTRL -- requirements
Module: hilo_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ITER, default 32, number of iteration cycles per multiply/divide.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port valid_in, input, 1, instruction funct valid this cycle.
REQ-005 The block SHALL have port funct, input, 6, instruction funct: MULTU=011001, DIVU=011011, MFHI=010000, MFLO=010010, others ALU/shifter.
REQ-006 The block SHALL have port divisor_zero, input, 1, the datapath divisor operand is zero.
REQ-007 The block SHALL have port res_hi and port res_lo, input, 32 each, iterative unit result.
REQ-008 The block SHALL have port ready, output, 1, high when a MULTU/DIVU can be accepted.
REQ-009 The block SHALL have port load, output, 1, operand-load strobe to the iterative unit.
REQ-010 The block SHALL have port mul_step and port div_step, output, 1 each, per-cycle iteration enables.
REQ-011 The block SHALL have port hilo_we, output, 1, Hi/Lo write strobe.
REQ-012 The block SHALL have port hi_out and port lo_out, output, 32 each, Hi/Lo register contents to the result mux.
REQ-013 The block SHALL have port stall, output, 1, hold pipeline (MFHI/MFLO hazard).
REQ-014 The block SHALL have port div_by_zero, output, 1, one-cycle error pulse.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, RUN, WRITE, encoded internally.
REQ-016 ready SHALL be 1 exactly in IDLE.
REQ-017 Accept occurs when valid_in=1, ready=1 and funct is MULTU or DIVU; op type and divisor_zero SHALL be latched at accept.
REQ-018 On accept with MULTU, or with DIVU and divisor_zero=0: IDLE->LOAD.
REQ-019 On accept with DIVU and divisor_zero=1: the block stays IDLE, pulses div_by_zero for the next cycle, and Hi/Lo are unchanged.
REQ-020 In LOAD, load=1 for one cycle; then LOAD->RUN with counter=0.
REQ-021 In RUN, mul_step (MULTU) or div_step (DIVU) SHALL be 1 each cycle; the counter increments; RUN->WRITE after ITER cycles (counter==ITER-1).
REQ-022 In WRITE, hilo_we=1 for one cycle; Hi<=res_hi and Lo<=res_lo at that edge; then WRITE->IDLE.
REQ-023 Latency: accept at edge T means LOAD in cycle T+1, RUN T+2..T+ITER+1, WRITE T+ITER+2, and new hi_out/lo_out visible plus ready=1 at T+ITER+3.
REQ-024 stall SHALL be combinational: 1 when valid_in=1, funct is MFHI or MFLO, and state!=IDLE; 0 otherwise.
REQ-025 MULTU/DIVU presented while not IDLE SHALL be ignored (no accept), and the requester holds valid_in.
REQ-026 Non-Hi/Lo functs SHALL never stall and never change state.
REQ-027 load, mul_step, div_step and hilo_we SHALL be mutually exclusive; mul_step and div_step never both 1.
REQ-028 The counter width SHALL be ceil(log2(ITER)) bits and SHALL NOT wrap within an operation.

Reset
REQ-029 While rst=0: state=IDLE, counter=0, hi_out=0, lo_out=0, and load, mul_step, div_step, hilo_we, div_by_zero all 0; ready=1.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no Hi/Lo write; after release the block accepts on the first valid edge.

Verification
REQ-031 MULTU accepted at T, res_hi=0x00000001, res_lo=0x80000000 -> load@T+1, mul_step high 32 cycles, hilo_we@T+34, hi_out=0x00000001 and lo_out=0x80000000 from T+35.
REQ-032 DIVU with divisor_zero=1 -> div_by_zero pulses 1 cycle, no load, hi_out/lo_out retain prior values, ready stays 1.
REQ-033 MFLO issued at T+5 of a MULTU -> stall=1 until WRITE completes, stall=0 at T+35 with new lo_out.
REQ-034 DIVU presented during RUN of a MULTU -> ignored; accepted at T+35 when held, div_step active for 32 cycles.
REQ-035 rst pulled low during RUN at counter=10 -> outputs zero asynchronously, no hilo_we; new MULTU after release completes normally.
REQ-036 funct=100000 (ADD) with valid_in during RUN -> stall=0, state and timing unaffected.
